// File: rtl/posit_pkg.sv
// posit_pkg: shared posit defaults and encoder state encoding.
package posit_pkg;
    localparam int N_DEF = 16;
    localparam int ES_DEF = 1;
    typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;
endpackage

// File: rtl/posit_pack.sv
// posit_pack: turns a normalised {sign, scale, fraction} triple into a rounded, clamped posit.
module posit_pack #(
    parameter int N = 16,
    parameter int ES = 1,
    parameter int FW = 32,
    parameter int SW = 7
) (
    input  logic                 sign,
    input  logic                 zero,
    input  logic signed [SW-1:0] scale,
    input  logic [FW-2:0]        frac,
    output logic [N-1:0]         posit
);
    localparam int W = N + ES + FW + 1;
    localparam logic signed [SW-1:0] LIM = SW'((N - 2) << ES);
    localparam logic [N-1:0] MAXP = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINP = N'(1);
    logic signed [SW-1:0] k;
    logic [SW-1:0] amt;
    logic [W-1:0] tmp, sh;
    logic [N-2:0] body;
    logic g, st;
    logic [N-1:0] rnd, mag;
    // Regime is seeded as "10" or "01" and stretched by shifting; N pad bits keep sticky exact.
    always_comb begin
        k = scale >>> ES;
        amt = k[SW-1] ? ~k : k;
        tmp = {~k[SW-1], k[SW-1], scale[ES-1:0], frac, {N{1'b0}}};
        sh = k[SW-1] ? tmp >> amt : $unsigned($signed(tmp) >>> amt);
        body = sh[W-1 -: N-1];
        g = sh[W-N];
        st = |sh[W-N-1:0];
        rnd = {1'b0, body} + N'(g & (st | body[0]));
        mag = zero ? '0
            : (scale > LIM || rnd[N-1]) ? MAXP
            : (scale < -LIM || rnd == '0) ? MINP
            : rnd;
        posit = sign ? -mag : mag;
    end
endmodule

// File: rtl/fixed_to_posit_enc.sv
// fixed_to_posit_enc: iterative signed fixed-point to posit encoder with valid/ready handshakes.
module fixed_to_posit_enc
    import posit_pkg::*;
#(
    parameter int FW = 32,
    parameter int FRAC = 16,
    parameter int N = N_DEF,
    parameter int ES = ES_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [FW-1:0] in_fixed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_posit
);
    localparam int SW = $clog2(FW) + 2;
    state_t state, state_nx;
    logic sign, zero;
    logic [FW-1:0] mag;
    logic signed [SW-1:0] scale;
    logic [N-1:0] packed_posit;

    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = in_valid ? NORM : IDLE;
            NORM: state_nx = (mag == '0 || mag[FW-1]) ? PACK : NORM;
            PACK: state_nx = DONE;
            DONE: state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sign <= 1'b0;
            zero <= 1'b0;
            mag <= '0;
            scale <= '0;
            out_posit <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                sign <= in_fixed[FW-1];
                zero <= 1'b0;
                mag <= in_fixed[FW-1] ? -in_fixed : in_fixed;
                scale <= SW'(FW - 1 - FRAC);
            end
            if (state == NORM && mag == '0) zero <= 1'b1;
            if (state == NORM && mag != '0 && !mag[FW-1]) begin
                mag <= mag << 1;
                scale <= scale - 1'b1;
            end
            if (state == PACK) out_posit <= packed_posit;
        end
    end

    posit_pack #(.N(N), .ES(ES), .FW(FW), .SW(SW)) u_pack (
        .sign(sign),
        .zero(zero),
        .scale(scale),
        .frac(mag[FW-2:0]),
        .posit(packed_posit)
    );
endmodule

// File: tb/tb_fixed_to_posit_enc.sv
// tb_fixed_to_posit_enc: directed and model-checked vectors for the fixed-to-posit encoder.
module tb_fixed_to_posit_enc;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid;
    logic [31:0] in_fixed = '0;
    logic [15:0] out_posit;
    logic [15:0] exp_q[$];
    int total = 0, bad = 0;

    fixed_to_posit_enc #(.FW(32), .FRAC(16), .N(16), .ES(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fixed(in_fixed), .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic int msb_of(input longint ax);
        int m = -1;
        for (int i = 0; i < 33; i++) if (ax[i]) m = i;
        return m;
    endfunction

    function automatic longint abs_of(input logic [31:0] x);
        longint ax = longint'($signed(x));
        return ax < 0 ? -ax : ax;
    endfunction

    // Builds the posit bit string from the regime/exponent/fraction rules, then rounds it.
    function automatic logic [15:0] model(input logic [31:0] x);
        longint ax = abs_of(x);
        int msb, sc, k, e, body;
        bit q[$];
        bit g, st;
        if (ax == 0) return 16'h0000;
        msb = msb_of(ax);
        sc = msb - 16;
        if (sc > 28) body = 32767;
        else if (sc < -28) body = 1;
        else begin
            k = sc >= 0 ? sc / 2 : -((1 - sc) / 2);
            e = sc - 2 * k;
            if (k >= 0) begin
                repeat (k + 1) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                repeat (-k) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            q.push_back(e[0]);
            for (int i = msb - 1; i >= 0; i--) q.push_back(ax[i]);
            while (q.size() < 17) q.push_back(1'b0);
            body = 0;
            for (int i = 0; i < 15; i++) body = body * 2 + int'(q[i]);
            g = q[15];
            st = 1'b0;
            for (int i = 16; i < q.size(); i++) st |= q[i];
            if (g && (st || body[0])) body++;
            if (body > 32767) body = 32767;
            if (body == 0) body = 1;
        end
        return x[31] ? 16'(-body) : 16'(body);
    endfunction

    function automatic int model_lat(input logic [31:0] x);
        longint ax = abs_of(x);
        return ax == 0 ? 2 : 31 - msb_of(ax) + 2;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) chk("unexpected_output", 32'(out_posit), 32'hDEAD);
            else begin
                chk("out_posit", 32'(out_posit), 32'(exp_q[0]));
                chk("in_ready_in_done", 32'(in_ready), 0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic wait_out(input logic [31:0] x);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 100);
        chk("latency", n, model_lat(x));
    endtask

    task automatic start(input logic [31:0] x);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 0, 1);
        in_fixed = x;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(x));
        #1;
        in_valid = 1'b0;
        in_fixed = $urandom;
    endtask

    task automatic convert(input logic [31:0] x, input bit has_lit, input logic [15:0] lit);
        if (has_lit) chk("model_literal", 32'(model(x)), 32'(lit));
        start(x);
        wait_out(x);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    logic [31:0] vec[7] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0003_0000, 32'h0000_0000,
                            32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [15:0] lit[7] = '{16'h4000, 16'hC000, 16'h5800, 16'h0000,
                            16'h0040, 16'h7FA0, 16'h8060};

    initial begin
        #2;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_out_posit", 32'(out_posit), 0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) convert(vec[i], 1'b1, lit[i]);
        // Backpressure: output must hold and a pending input must wait for IDLE.
        start(32'h0003_0000);
        wait_out(32'h0003_0000);
        in_fixed = 32'hFFFF_0000;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_after_release", 32'(in_ready), 1);
        @(posedge clk);
        exp_q.push_back(model(32'hFFFF_0000));
        #1;
        in_valid = 1'b0;
        in_fixed = 32'h1234_5678;
        wait_out(32'hFFFF_0000);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) convert($urandom >> $urandom_range(0, 31), 1'b0, 16'h0);
        // Asynchronous reset in the middle of normalisation.
        start(32'h0000_0001);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 0);
        chk("midreset_in_ready", 32'(in_ready), 1);
        chk("midreset_out_posit", 32'(out_posit), 0);
        exp_q.delete();
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        convert(32'h0000_0001, 1'b1, 16'h0040);
        convert(32'hFFFF_8000, 1'b1, 16'hD000);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
